multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle sequencing controller for the MIPS datapath: it replaces the single-cycle opcode decoder with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It drives every datapath mux and write enable, waits on a shared instruction/data memory through a ready handshake, and counts retired instructions. It supports the same opcode set as the existing decoder: lw, sw, addi, R-type, beq and bne.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- mem_ready  in  1  memory has completed the current read or write this cycle
- PCWrite, PCWriteCond, IorD, IRWrite  out  1 each  PC/IR/address-mux controls
- MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUsrcA  out  1 each  datapath controls
- BranchNE  out  1  invert the zero flag for the PCWriteCond qualification (bne)
- ALUsrcB  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUop  out  3  000 add, 001 sub, 010 decode funct field
- PCSource  out  2  00 ALU result, 01 ALUOut register
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retired  out  CNT_W  count of completed instructions

## Operation
- The state register uses the following states: IDLE, IF, ID, MA (memory address), MR (memory read), WBM (load write-back), MW (memory write), EXR, WBR, EXI, WBI, BR.
- Outputs are combinational from the state, opcode latch op_q and mem_ready. Any signal not listed for a state is 0.
- IDLE: all outputs 0. Always moves to IF on the next cycle.
- IF: MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=000, PCSource=00.
  - When mem_ready=1, IRWrite=1 and PCWrite=1 in the same cycle, and the FSM moves to ID.
  - Otherwise the FSM stays in IF and IRWrite and PCWrite stay 0.
- ID: ALUsrcA=0, ALUsrcB=11, ALUop=000. op_q <= opcode.
  - Next state: lw or sw goes to MA, 000000 to EXR, addi to EXI, beq or bne to BR.
  - Any other opcode: illegal=1 and the FSM returns to IF; that instruction is not counted.
- MA: ALUsrcA=1, ALUsrcB=10, ALUop=000. Next state is MR if op_q=lw, otherwise MW.
- MR: MemRead=1, IorD=1. Moves to WBM when mem_ready=1, otherwise holds.
- WBM: RegWrite=1, RegDst=0, MemtoReg=1. Next state IF.
- MW: MemWrite=1, IorD=1. Moves to IF when mem_ready=1, otherwise holds.
- EXR: ALUsrcA=1, ALUsrcB=00, ALUop=010. Next state WBR.
- WBR: RegWrite=1, RegDst=1, MemtoReg=0. Next state IF.
- EXI: ALUsrcA=1, ALUsrcB=10, ALUop=000. Next state WBI.
- WBI: RegWrite=1, RegDst=0, MemtoReg=0. Next state IF.
- BR: ALUsrcA=1, ALUsrcB=00, ALUop=001, PCWriteCond=1, PCSource=01, BranchNE=(op_q==000101). Next state IF.
- retired increments by 1 on each transition into IF from WBM, MW, WBR, WBI or BR.
  - It wraps modulo 2^CNT_W.
  - The transitions IDLE->IF and ID->IF (illegal) do not increment it.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, op_q=0, retired=0. Every output is 0 while in reset and in IDLE.
- After rst_n rises: one IDLE cycle, then IF on the second edge.
- Cycle counts with mem_ready=1 continuously: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, illegal 2 (IF, ID).
- Each cycle of mem_ready=0 in IF, MR or MW adds one cycle. There is no timeout.
- mem_ready is ignored in every state except IF, MR and MW.
- opcode is sampled only in ID. Changes to opcode in other states have no effect.
- Reset asserted mid-instruction aborts it immediately with no counter increment. A pending MemWrite drops in the same instant.

## Test plan
- Reset release, opcode=000000, mem_ready=1 -> states IDLE, IF, ID, EXR, WBR, IF. RegWrite=1 and RegDst=1 only in WBR, ALUop=010 in EXR, retired=1.
- lw (100011) with mem_ready low 2 cycles in IF and 3 cycles in MR -> IRWrite pulses once on the cycle mem_ready goes high. WBM has MemtoReg=1 and RegDst=0. Total 10 cycles, retired increments by 1.
- sw (101011) -> MemWrite=1 and IorD=1 only in MW, RegWrite never 1, 4 cycles.
- bne (000101) -> BR has PCWriteCond=1, BranchNE=1, ALUop=001, PCSource=01. Then beq -> same but BranchNE=0. 3 cycles each.
- opcode 111111 -> illegal=1 for exactly one cycle in ID, FSM back in IF, retired unchanged.
- Hold mem_ready=0 in MW, then pull rst_n low -> all outputs 0 immediately, retired=0. After release, IDLE then IF.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the MIPS datapath/memory.
// The sequencer is the master: it samples opcode/mem_ready and drives every control.
interface multicycle_control_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUsrcA;
    logic             BranchNE;
    logic [1:0]       ALUsrcB;
    logic [2:0]       ALUop;
    logic [1:0]       PCSource;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
               RegDst, RegWrite, ALUsrcA, BranchNE, ALUsrcB, ALUop, PCSource,
               illegal, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
               RegDst, RegWrite, ALUsrcA, BranchNE, ALUsrcB, ALUop, PCSource,
               illegal, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: steps lw/sw/addi/R-type/beq/bne through IF..WB,
// drives all datapath controls and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_IF, S_ID, S_MA, S_MR, S_WBM, S_MW,
        S_EXR, S_WBR, S_EXI, S_WBI, S_BR
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] retired_q;
    logic             op_legal;
    logic             retire;

    always_comb begin
        op_legal = 1'b0;
        case (bus.opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // An instruction retires on the edge that takes its last state back to IF.
    assign retire = (state == S_WBM) || (state == S_WBR) || (state == S_WBI) ||
                    (state == S_BR)  || ((state == S_MW) && bus.mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            if (retire) retired_q <= retired_q + CNT_ONE;
            case (state)
                S_IDLE: state <= S_IF;
                S_IF:   if (bus.mem_ready) state <= S_ID;
                S_ID: begin
                    op_q <= bus.opcode;
                    case (bus.opcode)
                        OP_LW, OP_SW:    state <= S_MA;
                        OP_RTYPE:        state <= S_EXR;
                        OP_ADDI:         state <= S_EXI;
                        OP_BEQ, OP_BNE:  state <= S_BR;
                        default:         state <= S_IF;
                    endcase
                end
                S_MA:   state <= (op_q == OP_LW) ? S_MR : S_MW;
                S_MR:   if (bus.mem_ready) state <= S_WBM;
                S_MW:   if (bus.mem_ready) state <= S_IF;
                S_EXR:  state <= S_WBR;
                S_EXI:  state <= S_WBI;
                S_WBM, S_WBR, S_WBI, S_BR: state <= S_IF;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.retired = retired_q;

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUsrcA     = 1'b0;
        bus.BranchNE    = 1'b0;
        bus.ALUsrcB     = 2'b00;
        bus.ALUop       = 3'b000;
        bus.PCSource    = 2'b00;
        bus.illegal     = 1'b0;
        case (state)
            S_IF: begin
                bus.MemRead = 1'b1;
                bus.ALUsrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            S_ID: begin
                bus.ALUsrcB = 2'b11;
                bus.illegal = ~op_legal;
            end
            S_MA, S_EXI: begin
                bus.ALUsrcA = 1'b1;
                bus.ALUsrcB = 2'b10;
            end
            S_MR: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_WBM: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MW: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            S_EXR: begin
                bus.ALUsrcA = 1'b1;
                bus.ALUop   = 3'b010;
            end
            S_WBR: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_WBI: bus.RegWrite = 1'b1;
            S_BR: begin
                bus.ALUsrcA     = 1'b1;
                bus.ALUop       = 3'b001;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
                bus.BranchNE    = (op_q == OP_BNE);
            end
            default: ;
        endcase
    end
endmodule
